// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Operands are latched on accept;
// the result is committed to HI/LO after a fixed MULT_CYCLES / DIV_CYCLES latency.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   a_q, b_q;
  logic          sgn_q;

  logic          accept_c, commit_c, mthi_c, mtlo_c;

  logic [63:0]   a_ext_c, b_ext_c, prod_c;
  logic          a_neg_c, b_neg_c;
  logic [31:0]   a_mag_c, b_mag_c, q_mag_c, r_mag_c, quot_c, rem_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next state, accept and commit strobes
  always_comb begin
    state_n  = state;
    accept_c = 1'b0;
    commit_c = 1'b0;
    mthi_c   = 1'b0;
    mtlo_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start && (md_op == OP_MULT || md_op == OP_MULTU)) begin
          state_n  = MUL;
          accept_c = 1'b1;
        end else if (start && (md_op == OP_DIV || md_op == OP_DIVU)) begin
          state_n  = DIV;
          accept_c = 1'b1;
        end else begin
          mthi_c = we && (md_op == OP_MTHI);
          mtlo_c = we && (md_op == OP_MTLO);
        end
      end
      MUL: begin
        if (cnt == CW'(MULT_CYCLES)) begin
          state_n  = IDLE;
          commit_c = 1'b1;
        end
      end
      DIV: begin
        if (cnt == CW'(DIV_CYCLES)) begin
          state_n  = IDLE;
          commit_c = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Product: extend per signedness, low 64 bits are correct for both forms
  always_comb begin
    a_ext_c = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    b_ext_c = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod_c  = a_ext_c * b_ext_c;
  end

  // Divider on magnitudes; 0x80000000 / -1 wraps naturally to 0x80000000
  always_comb begin
    a_neg_c = sgn_q && a_q[31];
    b_neg_c = sgn_q && b_q[31];
    a_mag_c = a_neg_c ? 32'(~a_q + 32'd1) : a_q;
    b_mag_c = b_neg_c ? 32'(~b_q + 32'd1) : b_q;
    q_mag_c = (b_mag_c == 32'd0) ? 32'd0 : a_mag_c / b_mag_c;
    r_mag_c = (b_mag_c == 32'd0) ? 32'd0 : a_mag_c % b_mag_c;
    quot_c  = (a_neg_c ^ b_neg_c) ? 32'(~q_mag_c + 32'd1) : q_mag_c;
    rem_c   = a_neg_c ? 32'(~r_mag_c + 32'd1) : r_mag_c;
  end

  // Latency counter, operand latches and busy flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      busy  <= 1'b0;
    end else begin
      busy <= (state_n != IDLE);
      if (accept_c) begin
        cnt   <= CW'(1);
        a_q   <= a;
        b_q   <= b;
        sgn_q <= ~md_op[0];
      end else if (commit_c) begin
        cnt <= '0;
      end else if (state != IDLE) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // HI/LO: commit result, or direct MTHI/MTLO writes while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit_c) begin
      if (state == MUL) begin
        hi <= prod_c[63:32];
        lo <= prod_c[31:0];
      end else if (b_q != 32'd0) begin
        hi <= rem_c;
        lo <= quot_c;
      end
    end else if (mthi_c) begin
      hi <= a;
    end else if (mtlo_c) begin
      lo <= a;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO/latency queued at issue, checked at commit.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic        we;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .we(we),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model written independently with 64-bit native arithmetic
  task automatic model(input logic [2:0] op, input logic [31:0] oa, ob, hi0, lo0,
                       output logic [31:0] ehi, elo);
    longint      sa, sb_, sq, sr;
    logic [63:0] ua, ub, up;
    sa = longint'(signed'(oa));
    sb_ = longint'(signed'(ob));
    ua = {32'd0, oa};
    ub = {32'd0, ob};
    ehi = hi0;
    elo = lo0;
    case (op)
      3'd0: begin up = 64'(sa * sb_); ehi = up[63:32]; elo = up[31:0]; end
      3'd1: begin up = ua * ub; ehi = up[63:32]; elo = up[31:0]; end
      3'd2: if (ob != 0) begin
        sq = sa / sb_; sr = sa % sb_;
        elo = 32'(sq); ehi = 32'(sr);
      end
      3'd3: if (ob != 0) begin
        elo = 32'(ua / ub); ehi = 32'(ua % ub);
      end
      default: ;
    endcase
  endtask

  // Issue one op, scramble inputs after accept, count busy cycles (bounded)
  task automatic run_op(input logic [2:0] op, input logic [31:0] oa, ob, output int cyc);
    start = 1'b1; md_op = op; a = oa; b = ob;
    step();
    start = 1'b0; md_op = 3'd7; a = $urandom; b = $urandom;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      step();
    end
  endtask

  task automatic push(input logic [31:0] ehi, elo, input int cyc);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; we = 1'b0; md_op = 3'd7; a = '0; b = '0;
    repeat (2) step();
    vectors += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h want=0", hi); end
    if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h want=0", lo); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_mult();
    int cyc;
    exp_t e;
    logic [31:0] ehi, elo, ra, rb;
    push(32'hFFFFFFFF, 32'hFFFFFFF1, 5);
    run_op(3'd0, 32'hFFFFFFFD, 32'd5, cyc);
    e = sb.pop_front();
    vectors += 3;
    if (cyc !== e.cyc) begin errors++; $display("FAIL mult_cyc got=%0d want=%0d", cyc, e.cyc); end
    if (hi !== e.hi) begin errors++; $display("FAIL mult_hi got=%h want=%h", hi, e.hi); end
    if (lo !== e.lo) begin errors++; $display("FAIL mult_lo got=%h want=%h", lo, e.lo); end
    push(32'hFFFFFFFE, 32'h00000001, 5);
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    e = sb.pop_front();
    vectors += 3;
    if (cyc !== e.cyc) begin errors++; $display("FAIL multu_cyc got=%0d want=%0d", cyc, e.cyc); end
    if (hi !== e.hi) begin errors++; $display("FAIL multu_hi got=%h want=%h", hi, e.hi); end
    if (lo !== e.lo) begin errors++; $display("FAIL multu_lo got=%h want=%h", lo, e.lo); end
    for (int i = 0; i < 6; i++) begin
      logic [2:0] op;
      op = 3'(i % 2);
      ra = $urandom; rb = $urandom;
      model(op, ra, rb, hi, lo, ehi, elo);
      push(ehi, elo, 5);
      run_op(op, ra, rb, cyc);
      e = sb.pop_front();
      vectors += 2;
      if (cyc !== e.cyc) begin errors++; $display("FAIL rmul_cyc op=%0d got=%0d want=%0d", op, cyc, e.cyc); end
      if ({hi, lo} !== {e.hi, e.lo})
        begin errors++; $display("FAIL rmul_res op=%0d a=%h b=%h got=%h_%h want=%h_%h", op, ra, rb, hi, lo, e.hi, e.lo); end
    end
  endtask

  task automatic test_div();
    int cyc;
    exp_t e;
    logic [31:0] ehi, elo, ra, rb;
    push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, cyc);
    e = sb.pop_front();
    vectors += 3;
    if (cyc !== e.cyc) begin errors++; $display("FAIL div_cyc got=%0d want=%0d", cyc, e.cyc); end
    if (hi !== e.hi) begin errors++; $display("FAIL div_hi got=%h want=%h", hi, e.hi); end
    if (lo !== e.lo) begin errors++; $display("FAIL div_lo got=%h want=%h", lo, e.lo); end
    push(32'h00000001, 32'h7FFFFFFC, 10);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, cyc);
    e = sb.pop_front();
    vectors += 2;
    if (hi !== e.hi) begin errors++; $display("FAIL divu_hi got=%h want=%h", hi, e.hi); end
    if (lo !== e.lo) begin errors++; $display("FAIL divu_lo got=%h want=%h", lo, e.lo); end
    push(32'h00000000, 32'h80000000, 10);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, cyc);
    e = sb.pop_front();
    vectors += 1;
    if ({hi, lo} !== {e.hi, e.lo}) begin errors++; $display("FAIL div_ovf got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); end
    for (int i = 0; i < 8; i++) begin
      logic [2:0] op;
      op = 3'(2 + i % 2);
      ra = $urandom;
      rb = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 6) rb = 32'hFFFFFFF3;
      if (rb == 0) rb = 32'd3;
      model(op, ra, rb, hi, lo, ehi, elo);
      push(ehi, elo, 10);
      run_op(op, ra, rb, cyc);
      e = sb.pop_front();
      vectors += 2;
      if (cyc !== e.cyc) begin errors++; $display("FAIL rdiv_cyc op=%0d got=%0d want=%0d", op, cyc, e.cyc); end
      if ({hi, lo} !== {e.hi, e.lo})
        begin errors++; $display("FAIL rdiv_res op=%0d a=%h b=%h got=%h_%h want=%h_%h", op, ra, rb, hi, lo, e.hi, e.lo); end
    end
  endtask

  task automatic test_move_and_div_zero();
    int cyc;
    exp_t e;
    // MTHI with start also high: md_op 4 is not a start op, so the write applies
    we = 1'b1; start = 1'b1; md_op = 3'd4; a = 32'h00001234;
    step();
    we = 1'b0; start = 1'b0; md_op = 3'd7;
    vectors += 2;
    if (hi !== 32'h00001234) begin errors++; $display("FAIL mthi got=%h want=00001234", hi); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b want=0", busy); end
    we = 1'b1; md_op = 3'd5; a = 32'h0BADF00D;
    step();
    we = 1'b0; md_op = 3'd7;
    vectors += 1;
    if (lo !== 32'h0BADF00D) begin errors++; $display("FAIL mtlo got=%h want=0badf00d", lo); end
    // Invalid op with start is ignored
    start = 1'b1; md_op = 3'd6; a = 32'd9; b = 32'd9;
    step();
    start = 1'b0;
    vectors += 1;
    if (busy !== 1'b0) begin errors++; $display("FAIL bad_op_busy got=%b want=0", busy); end
    push(32'h00001234, 32'h0BADF00D, 10);
    run_op(3'd3, 32'd7, 32'd0, cyc);
    e = sb.pop_front();
    vectors += 3;
    if (cyc !== e.cyc) begin errors++; $display("FAIL divz_cyc got=%0d want=%0d", cyc, e.cyc); end
    if (hi !== e.hi) begin errors++; $display("FAIL divz_hi got=%h want=%h", hi, e.hi); end
    if (lo !== e.lo) begin errors++; $display("FAIL divz_lo got=%h want=%h", lo, e.lo); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit mid_ok;
    exp_t e;
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    push(32'd2, 32'd14, 10);
    start = 1'b1; md_op = 3'd2; a = 32'd100; b = 32'd7;
    step();
    start = 1'b0; md_op = 3'd7;
    cyc = 0; mid_ok = 1'b1;
    while (busy && cyc < 100) begin
      cyc++;
      if (hi !== hi0 || lo !== lo0) mid_ok = 1'b0;
      start = (cyc == 3);
      we    = (cyc == 5);
      md_op = (cyc == 3) ? 3'd0 : (cyc == 5) ? 3'd5 : 3'd7;
      a     = (cyc == 3) ? 32'd55 : 32'hDEAD0000 + 32'(cyc);
      b     = 32'd3;
      step();
    end
    start = 1'b0; we = 1'b0;
    e = sb.pop_front();
    vectors += 4;
    if (mid_ok !== 1'b1) begin errors++; $display("FAIL b2b_mid_hold got=%b want=1", mid_ok); end
    if (cyc !== e.cyc) begin errors++; $display("FAIL b2b_cyc got=%0d want=%0d", cyc, e.cyc); end
    if (hi !== e.hi) begin errors++; $display("FAIL b2b_hi got=%h want=%h", hi, e.hi); end
    if (lo !== e.lo) begin errors++; $display("FAIL b2b_lo got=%h want=%h", lo, e.lo); end
    // New op issued in the cycle right after busy drops
    push(32'd0, 32'd12, 5);
    run_op(3'd1, 32'd3, 32'd4, cyc);
    e = sb.pop_front();
    vectors += 2;
    if (cyc !== e.cyc) begin errors++; $display("FAIL b2b2_cyc got=%0d want=%0d", cyc, e.cyc); end
    if ({hi, lo} !== {e.hi, e.lo}) begin errors++; $display("FAIL b2b2_res got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    exp_t e;
    we = 1'b1; md_op = 3'd4; a = 32'h0000AAAA;
    step();
    we = 1'b0;
    start = 1'b1; md_op = 3'd0; a = 32'd16; b = 32'd32;
    step();
    start = 1'b0; md_op = 3'd7;
    step();
    reset = 1'b0;
    #1;
    vectors += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b want=0", busy); end
    if (hi !== 32'd0) begin errors++; $display("FAIL rmid_hi got=%h want=0", hi); end
    if (lo !== 32'd0) begin errors++; $display("FAIL rmid_lo got=%h want=0", lo); end
    step();
    reset = 1'b1;
    repeat (8) step();
    vectors += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_late_busy got=%b want=0", busy); end
    if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL rmid_late_commit got=%h_%h want=0", hi, lo); end
    push(32'd0, 32'd42, 5);
    run_op(3'd0, 32'd6, 32'd7, cyc);
    e = sb.pop_front();
    vectors += 2;
    if (cyc !== e.cyc) begin errors++; $display("FAIL rmid_mul_cyc got=%0d want=%0d", cyc, e.cyc); end
    if ({hi, lo} !== {e.hi, e.lo}) begin errors++; $display("FAIL rmid_mul_res got=%h_%h want=%h_%h", hi, lo, e.hi, e.lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_move_and_div_zero();
    test_back_to_back();
    test_reset_mid();
    vectors += 1;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
